stream_unbuffer: RTL and testbench

Memory-to-pixel-stream path: the read-side counterpart of the camera write buffer. Accepts 64-bit words returned by the DMA burst reader, buffers them in a single-clock FIFO and serializes each word into eight 8-bit bytes on a valid/ready output stream. Issues burst requests only when the FIFO has room for a whole burst, so the reader never overflows it.

---
 rtl/stream_unbuffer_pkg.sv | 16 +
 rtl/stream_unbuffer_if.sv | 26 ++
 rtl/stream_unbuffer_serializer.sv | 57 +++++
 rtl/stream_unbuffer.sv | 118 +++++++++++
 tb/tb_stream_unbuffer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/stream_unbuffer_pkg.sv
// Shared definitions for the memory-to-pixel-stream read path.
package stream_pkg;

    localparam int DEFAULT_DEPTH     = 512;
    localparam int DEFAULT_BURST_LEN = 16;

    // Count width able to represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [7:0] byte_lane(input logic [63:0] word, input logic [2:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/stream_unbuffer_if.sv
// Read-data, burst-credit and byte-stream signals of the unbuffer block.
interface stream_unbuffer_if #(
    parameter int CNT_W = 10
);
    logic             din_valid;
    logic             din_ready;
    logic [63:0]      din;
    logic             burst_req;
    logic             burst_ack;
    logic             dout_valid;
    logic             dout_ready;
    logic [7:0]       dout;
    logic [CNT_W-1:0] fifo_cnt;
    logic             err;

    modport master (
        input  din_valid, din, burst_ack, dout_ready,
        output din_ready, burst_req, dout_valid, dout, fifo_cnt, err
    );

    modport slave (
        output din_valid, din, burst_ack, dout_ready,
        input  din_ready, burst_req, dout_valid, dout, fifo_cnt, err
    );

endinterface

// File: rtl/stream_unbuffer_serializer.sv
// Word-to-byte serializer: emits the loaded word least-significant byte first.
module stream_unbuffer_serializer
    import stream_pkg::*;
#(
    parameter int INLOGBITS  = 6,
    parameter int OUTLOGBITS = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [(1<<INLOGBITS)-1:0]  in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [(1<<OUTLOGBITS)-1:0] out_data
);
    localparam int IDX_W = INLOGBITS - OUTLOGBITS;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    logic [(1<<INLOGBITS)-1:0]  word_reg;
    logic [IDX_W-1:0]           idx_reg;
    logic [IDX_W-1:0]           idx_next;
    logic                       valid_reg;
    logic [(1<<OUTLOGBITS)-1:0] data_reg;
    logic                       last_hs;
    logic                       load;

    assign idx_next  = idx_reg + IDX_W'(1);
    assign last_hs   = valid_reg && out_ready && (idx_reg == LAST_IDX);
    // Accepting a new word on the final byte's handshake keeps words gapless.
    assign in_ready  = !valid_reg || last_hs;
    assign load      = in_valid && in_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg  <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            word_reg  <= in_data;
            idx_reg   <= '0;
            valid_reg <= 1'b1;
            data_reg  <= byte_lane(in_data, '0);
        end else if (valid_reg && out_ready) begin
            if (idx_reg == LAST_IDX) begin
                valid_reg <= 1'b0;
            end else begin
                idx_reg  <= idx_next;
                data_reg <= byte_lane(word_reg, idx_next);
            end
        end
    end

endmodule

// File: rtl/stream_unbuffer.sv
// Read-side stream buffer: credit-gated burst requests, word FIFO, byte serializer.
module stream_unbuffer
    import stream_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int CNT_W     = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    stream_unbuffer_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]   FULL_CNT     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W:0]     BURST_CREDIT = (CNT_W+1)'(BURST_LEN);
    localparam logic [CNT_W:0]     OUT_ONE      = (CNT_W+1)'(1);
    localparam logic [CNT_W+1:0]   GATE_LIMIT   = (CNT_W+2)'(DEPTH - BURST_LEN);
    localparam logic [AW-1:0]      PTR_ONE      = AW'(1);

    logic             running_reg;
    logic             err_reg;
    logic             collide_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W:0]   outstanding_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [63:0]      mem [DEPTH];
    logic [63:0]      ram_q;

    logic             wr_en;
    logic             head_ok;
    logic             pop;
    logic             ser_in_ready;
    logic             grant;
    logic             take;
    logic             burst_req;
    logic [CNT_W+1:0] committed;

    assign bus.din_ready = (cnt_reg != FULL_CNT);
    assign wr_en         = bus.din_valid && bus.din_ready;

    // A word written at the slot being read this edge is not in ram_q yet; wait one cycle.
    assign head_ok     = (cnt_reg != '0) && !collide_reg;
    assign pop         = head_ok && ser_in_ready;
    assign rd_ptr_next = pop ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;

    assign committed = {2'b00, cnt_reg} + {1'b0, outstanding_reg};
    assign burst_req = running_reg && (committed <= GATE_LIMIT);
    assign grant     = bus.burst_ack && burst_req;
    assign take      = wr_en && (outstanding_reg != '0);

    assign bus.burst_req = burst_req;
    assign bus.fifo_cnt  = cnt_reg;
    assign bus.err       = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_reg     <= 1'b0;
            err_reg         <= 1'b0;
            collide_reg     <= 1'b0;
            cnt_reg         <= '0;
            outstanding_reg <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            running_reg <= running_reg | start;

            if ((bus.burst_ack && !burst_req) || (wr_en && outstanding_reg == '0)) begin
                err_reg <= 1'b1;
            end

            case ({grant, take})
                2'b10:   outstanding_reg <= outstanding_reg + BURST_CREDIT;
                2'b01:   outstanding_reg <= outstanding_reg - OUT_ONE;
                2'b11:   outstanding_reg <= outstanding_reg + BURST_CREDIT - OUT_ONE;
                default: ;
            endcase

            case ({wr_en, pop})
                2'b10:   cnt_reg <= cnt_reg + CNT_ONE;
                2'b01:   cnt_reg <= cnt_reg - CNT_ONE;
                default: ;
            endcase

            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            rd_ptr_reg  <= rd_ptr_next;
            collide_reg <= wr_en && (wr_ptr_reg == rd_ptr_next);
        end
    end

    // Block RAM with registered read; the address is the post-pop read pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= bus.din;
        end
        ram_q <= mem[rd_ptr_next];
    end

    stream_unbuffer_serializer #(
        .INLOGBITS (6),
        .OUTLOGBITS(3)
    ) u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (head_ok),
        .in_ready (ser_in_ready),
        .in_data  (ram_q),
        .out_valid(bus.dout_valid),
        .out_ready(bus.dout_ready),
        .out_data (bus.dout)
    );

endmodule

// File: tb/tb_stream_unbuffer.sv
// Randomized bench for stream_unbuffer against a byte-queue and credit model.
module tb_stream_unbuffer;
    import stream_pkg::*;

    localparam int DEPTH = 512;
    localparam int BL    = 16;
    localparam int CW    = cnt_width(DEPTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    stream_unbuffer_if #(.CNT_W(CW)) bus();

    stream_unbuffer #(
        .DEPTH    (DEPTH),
        .BURST_LEN(BL),
        .CNT_W    (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    int  cyc = 0;
    int  pending, grants, beats_in, bytes_out, word_k;
    int  ack_budget, ready_mode, valid_pct, beat_lim, byte_lim;
    int  first_in_cyc, first_out_cyc, gaps;
    bit  running_m, err_m, extra_req, stray_req, start_req, gap_watch, done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] word_of(input int k);
        return 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
    endfunction

    // One clock: compare outputs to the model, advance the model, drive the next inputs.
    task automatic cycle();
        bit hs_in, hs_ack, hs_out, req_exp;
        int fifo_exp;
        logic [63:0] w;
        @(negedge clk);
        cyc++;
        fifo_exp = beats_in - (bytes_out + int'(bus.dout_valid) + 7) / 8;
        req_exp  = running_m && (DEPTH - fifo_exp - pending >= BL);
        check("err", bus.err, err_m);
        check("fifo_cnt", bus.fifo_cnt, fifo_exp);
        check("din_ready", bus.din_ready, fifo_exp != DEPTH);
        check("burst_req", bus.burst_req, req_exp);
        if (bus.dout_valid) begin
            if (exp_q.size() == 0) check("dout_spurious", 1, 0);
            else check("dout", bus.dout, exp_q[0]);
            if (first_out_cyc < 0) first_out_cyc = cyc;
        end
        if (gap_watch && first_out_cyc >= 0 && exp_q.size() > 0 && !bus.dout_valid) gaps++;

        hs_in  = bus.din_valid && bus.din_ready;
        hs_ack = bus.burst_ack && req_exp;
        hs_out = bus.dout_valid && bus.dout_ready;
        if (bus.burst_ack && !req_exp) err_m = 1'b1;
        if (hs_in && pending == 0) err_m = 1'b1;
        if (hs_ack) begin
            pending += BL;
            grants++;
            if (ack_budget > 0) ack_budget--;
            $display("burst grant %0d at cycle %0d", grants, cyc);
        end
        if (hs_in) begin
            if (pending > 0) pending--;
            w = word_of(word_k);
            for (int i = 0; i < 8; i++) exp_q.push_back(w[8*i +: 8]);
            if (first_in_cyc < 0) first_in_cyc = cyc;
            word_k++;
            beats_in++;
            extra_req = 1'b0;
            if (beat_lim > 0) beat_lim--;
        end
        if (hs_out) begin
            void'(exp_q.pop_front());
            bytes_out++;
            if (byte_lim > 0) byte_lim--;
        end
        if (start) running_m = 1'b1;

        @(posedge clk);
        #1;
        start     = start_req;
        start_req = 1'b0;
        bus.burst_ack = stray_req || (ack_budget > 0 && bus.burst_req);
        stray_req = 1'b0;
        if (!(bus.din_valid && !hs_in)) begin
            bus.din_valid = (extra_req || (pending > 0 && beat_lim != 0)) &&
                            ($urandom_range(0, 99) < valid_pct);
        end
        bus.din = word_of(word_k);
        case (ready_mode)
            0:       bus.dout_ready = 1'b0;
            1:       bus.dout_ready = 1'b1;
            2:       bus.dout_ready = !bus.dout_ready;
            3:       bus.dout_ready = 1'($urandom_range(0, 1));
            default: bus.dout_ready = (byte_lim > 0);
        endcase
    endtask

    // Asynchronous reset from wherever the bench currently is in the cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bus.burst_ack  = 1'b0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        exp_q.delete();
        pending = 0; running_m = 1'b0; err_m = 1'b0;
        beats_in = 0; bytes_out = 0; ack_budget = 0; beat_lim = -1; byte_lim = 0;
        extra_req = 1'b0; stray_req = 1'b0; start_req = 1'b0;
        first_in_cyc = -1; first_out_cyc = -1; gap_watch = 1'b0; gaps = 0;
        #1;
        check("rst_din_ready", bus.din_ready, 1);
        check("rst_burst_req", bus.burst_req, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_fifo_cnt", bus.fifo_cnt, 0);
        check("rst_err", bus.err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.din = '0;
        word_k = 0; grants = 0; valid_pct = 100; ready_mode = 1;
        do_reset();

        // Idle without start: no requests, nothing emitted.
        repeat (20) cycle();

        // Stray ack before start raises err and grants no credit.
        stray_req = 1'b1;
        repeat (3) cycle();
        check("err_stray", bus.err, 1);

        // Stalled output: fill until the credit gate closes.
        start_req = 1'b1; ready_mode = 0; ack_budget = 1000; valid_pct = 70;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            cycle();
            if (t > 20 && pending == 0 && !bus.burst_req) done = 1'b1;
        end
        check("fill_done", done, 1);
        check("fill_grants", grants, DEPTH / BL);
        // One word of the 512 already sits in the serializer.
        check("fill_cnt", bus.fifo_cnt, DEPTH - 1);
        extra_req = 1'b1; ack_budget = 0;
        for (int t = 0; t < 20 && extra_req; t++) cycle();
        cycle();
        check("full_cnt", bus.fifo_cnt, DEPTH);
        check("full_ready", bus.din_ready, 0);
        ready_mode = 3;
        for (int t = 0; t < 12000 && exp_q.size() > 0; t++) cycle();
        check("drain_left", exp_q.size(), 0);

        // Single burst, ready high: latency and gapless bytes 0x00..0x7F.
        do_reset();
        word_k = 0; grants = 0;
        ready_mode = 1; valid_pct = 100; ack_budget = 1; start_req = 1'b1; gap_watch = 1'b1;
        for (int t = 0; t < 300 && !(beats_in == 16 && exp_q.size() == 0); t++) cycle();
        check("b1_bytes", bytes_out, 128);
        check("b1_latency", first_out_cyc - first_in_cyc, 3);
        check("b1_gaps", gaps, 0);
        gap_watch = 1'b0;

        // Toggling ready with gappy input.
        ready_mode = 2; ack_budget = 3; valid_pct = 60;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            cycle();
            if (ack_budget == 0 && pending == 0 && exp_q.size() == 0) done = 1'b1;
        end
        check("toggle_done", done, 1);
        check("toggle_bytes", bytes_out, 128 + 3 * BL * 8);

        // Beat with no credit: err set, word still emitted.
        do_reset();
        ready_mode = 1; valid_pct = 100; extra_req = 1'b1;
        for (int t = 0; t < 60 && (extra_req || exp_q.size() > 0); t++) cycle();
        check("extra_bytes", bytes_out, 8);
        check("extra_err", bus.err, 1);

        // Reset mid-burst with 7 queued words and the serializer at byte 3.
        do_reset();
        start_req = 1'b1; ack_budget = 1; beat_lim = 8; byte_lim = 3; ready_mode = 4;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            cycle();
            if (bus.fifo_cnt == 7 && bytes_out == 3 && beats_in == 8) done = 1'b1;
        end
        check("mid_reached", done, 1);
        check("mid_dout", bus.dout, 8'(word_of(word_k - 8) >> 24));
        do_reset();
        ready_mode = 1;
        repeat (30) cycle();
        check("post_rst_req", bus.burst_req, 0);
        check("post_rst_valid", bus.dout_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
